// File: rtl/timer_multi.sv
// Multi-channel tick timer: a shared prescaler produces TICK, a 32-bit UPTIME counts ticks,
// and NCH compare channels (periodic/one-shot) raise sticky flags and maskable IRQs.
module timer_multi #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NCH      = 2,
  parameter int WIDTH    = 32
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           WE,
  input  logic [5:0]     ADDR,
  input  logic [31:0]    WD,
  output logic [31:0]    RD,
  output logic [NCH-1:0] IRQ,
  output logic           TICK
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0]    r_presc;
  logic [31:0]      r_uptime;
  logic             w_tick;
  logic [NCH-1:0]   w_en;
  logic [NCH-1:0]   w_mode;
  logic [NCH-1:0]   w_ie;
  logic [NCH-1:0]   w_flag;
  logic [WIDTH-1:0] w_cmp [NCH];
  logic [WIDTH-1:0] w_cnt [NCH];

  assign w_tick = (r_presc == PW'(DIV - 1));
  assign TICK   = w_tick;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc  <= '0;
      r_uptime <= '0;
    end else if (w_tick) begin
      r_presc  <= '0;
      r_uptime <= r_uptime + 32'd1;
    end else begin
      r_presc  <= r_presc + PW'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             r_en;
    logic             r_mode;
    logic             r_ie;
    logic             r_flag;
    logic [WIDTH-1:0] r_cmp;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_nxt;
    logic             w_sel;
    logic             w_step;
    logic             w_hit;

    assign w_sel  = WE && !ADDR[5] && (ADDR[4:2] == 3'(g));
    assign w_step = w_tick && r_en;
    assign w_nxt  = r_cnt + WIDTH'(1);
    assign w_hit  = w_step && (r_cmp != '0) && (w_nxt == r_cmp);

    // Statement order sets priority: bus writes override the tick update,
    // except that a flag set beats a same-edge W1C clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        r_en   <= 1'b0;
        r_mode <= 1'b0;
        r_ie   <= 1'b0;
        r_flag <= 1'b0;
        r_cmp  <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_step) r_cnt <= w_hit ? (r_mode ? '0 : r_cmp) : w_nxt;
        if (w_hit && !r_mode) r_en <= 1'b0;
        if (w_sel && (ADDR[1:0] == 2'd3) && WD[0]) r_flag <= 1'b0;
        if (w_hit) r_flag <= 1'b1;
        if (w_sel) begin
          case (ADDR[1:0])
            2'd0: begin
              r_en   <= WD[0];
              r_mode <= WD[1];
              r_ie   <= WD[2];
            end
            2'd1:    r_cmp <= WD[WIDTH-1:0];
            2'd2:    r_cnt <= WD[WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end

    assign w_en[g]   = r_en;
    assign w_mode[g] = r_mode;
    assign w_ie[g]   = r_ie;
    assign w_flag[g] = r_flag;
    assign w_cmp[g]  = r_cmp;
    assign w_cnt[g]  = r_cnt;
    assign IRQ[g]    = r_flag & r_ie;
  end

  always_comb begin
    RD = '0;
    if (ADDR == 6'h20) RD = r_uptime;
    for (int c = 0; c < NCH; c++) begin
      if (!ADDR[5] && (ADDR[4:2] == 3'(c))) begin
        case (ADDR[1:0])
          2'd0:    RD[2:0] = {w_ie[c], w_mode[c], w_en[c]};
          2'd1:    RD[WIDTH-1:0] = w_cmp[c];
          2'd2:    RD[WIDTH-1:0] = w_cnt[c];
          default: RD[0] = w_flag[c];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: a 2-channel 32-bit instance checked against a tick-level model,
// plus a 1-channel 8-bit instance for counter wrap.
module tb_timer_multi;
  localparam int DIV = 50;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        WE = 1'b0;
  logic [5:0]  ADDR = '0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic [1:0]  IRQ;
  logic        TICK;

  logic        b_we = 1'b0;
  logic [5:0]  b_addr = '0;
  logic [31:0] b_wd = '0;
  logic [31:0] b_rd;
  logic [0:0]  b_irq;
  logic        b_tick;

  int n_vec = 0;
  int n_err = 0;

  always #10 CLK = ~CLK;

  timer_multi #(.CLK_FREQ(50_000_000), .TICK_HZ(1_000_000), .NCH(2), .WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .ADDR(ADDR), .WD(WD),
    .RD(RD), .IRQ(IRQ), .TICK(TICK)
  );

  timer_multi #(.CLK_FREQ(50_000_000), .TICK_HZ(1_000_000), .NCH(1), .WIDTH(8)) dut_w (
    .CLK(CLK), .RESET_N(RESET_N), .WE(b_we), .ADDR(b_addr), .WD(b_wd),
    .RD(b_rd), .IRQ(b_irq), .TICK(b_tick)
  );

  // Reference model of the 2-channel instance, advanced once per rising edge.
  logic        m_en [2];
  logic        m_mode [2];
  logic        m_ie [2];
  logic        m_flag [2];
  logic [31:0] m_cmp [2];
  logic [31:0] m_cnt [2];
  logic [31:0] m_up;
  int          m_cyc;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
      m_cmp[c] = '0; m_cnt[c] = '0;
    end
    m_up = '0;
    m_cyc = 0;
  endfunction

  function automatic logic m_tick();
    return (m_cyc % DIV) == DIV - 1;
  endfunction

  function automatic logic [1:0] m_irq();
    return {m_flag[1] & m_ie[1], m_flag[0] & m_ie[0]};
  endfunction

  function automatic void model_edge();
    logic        tick;
    logic        hit;
    logic [31:0] nxt;
    tick = m_tick();
    for (int c = 0; c < 2; c++) begin
      hit = 0;
      if (tick && m_en[c]) begin
        nxt = m_cnt[c] + 32'd1;
        if (m_cmp[c] != 0 && nxt == m_cmp[c]) begin
          hit = 1;
          m_flag[c] = 1;
          if (m_mode[c]) m_cnt[c] = 0;
          else begin
            m_cnt[c] = m_cmp[c];
            m_en[c] = 0;
          end
        end else begin
          m_cnt[c] = nxt;
        end
      end
      if (WE && ADDR < 6'd8 && ADDR[2] == c[0]) begin
        case (ADDR[1:0])
          2'd0: begin m_en[c] = WD[0]; m_mode[c] = WD[1]; m_ie[c] = WD[2]; end
          2'd1: m_cmp[c] = WD;
          2'd2: m_cnt[c] = WD;
          default: if (WD[0] && !hit) m_flag[c] = 0;
        endcase
      end
    end
    if (tick) m_up = m_up + 32'd1;
    m_cyc++;
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    logic [31:0] r;
    int c;
    r = '0;
    c = int'(a[2]);
    if (a == 6'h20) r = m_up;
    else if (a < 6'd8) begin
      case (a[1:0])
        2'd0:    r = {29'd0, m_ie[c], m_mode[c], m_en[c]};
        2'd1:    r = m_cmp[c];
        2'd2:    r = m_cnt[c];
        default: r = {31'd0, m_flag[c]};
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    if (RESET_N) model_edge();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    WE = 1'b1; ADDR = a; WD = d;
    step();
    WE = 1'b0;
  endtask

  task automatic wr_b(input logic [5:0] a, input logic [31:0] d);
    b_we = 1'b1; b_addr = a; b_wd = d;
    step();
    b_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] a;
    logic       exp_t;
    RESET_N = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 9; i++) begin
      a = (i == 8) ? 6'h20 : 6'(i);
      ADDR = a; #1;
      n_vec++;
      if (RD !== 32'd0) begin n_err++; $display("FAIL reset_rd addr=%0h: got %0h want 0", a, RD); end
    end
    n_vec++;
    if (IRQ !== 2'b00 || TICK !== 1'b0)
      begin n_err++; $display("FAIL reset_out: got irq=%b tick=%b want 00/0", IRQ, TICK); end
    RESET_N = 1'b1;
    ADDR = 6'h20;
    for (int i = 0; i < 250; i++) begin
      exp_t = (i % DIV) == DIV - 1;
      n_vec++;
      if (TICK !== exp_t) begin n_err++; $display("FAIL tick_cycle%0d: got %b want %b", i, TICK, exp_t); end
      step();
      if (i == 49) begin
        n_vec++;
        if (RD !== 32'd1) begin n_err++; $display("FAIL uptime_first: got %0d want 1", RD); end
      end
    end
    n_vec++;
    if (RD !== 32'd5 || RD !== m_up) begin n_err++; $display("FAIL uptime_250: got %0d want 5", RD); end
  endtask

  task automatic test_periodic();
    int   ticks;
    logic got;
    wr(6'd1, 32'd3);
    wr(6'd0, 32'd7);
    for (int pass = 0; pass < 2; pass++) begin
      ticks = 0; got = 0;
      for (int i = 0; i < 5 * DIV && !got; i++) begin
        if (TICK) ticks++;
        step();
        n_vec++;
        if (IRQ !== m_irq()) begin n_err++; $display("FAIL periodic_irq_track: got %b want %b", IRQ, m_irq()); end
        got = IRQ[0];
      end
      n_vec++;
      if (!got || ticks != 3) begin n_err++; $display("FAIL periodic_ticks pass%0d: got irq=%b ticks=%0d want 1/3", pass, got, ticks); end
      ADDR = 6'd2; #1;
      n_vec++;
      if (RD !== 32'd0) begin n_err++; $display("FAIL periodic_cnt: got %0d want 0", RD); end
      if (pass == 0) begin
        wr(6'd3, 32'd1);
        n_vec++;
        if (IRQ[0] !== 1'b0) begin n_err++; $display("FAIL periodic_w1c: got irq0=%b want 0", IRQ[0]); end
      end
    end
  endtask

  task automatic test_oneshot();
    int   ticks;
    logic got;
    wr(6'd5, 32'd2);
    wr(6'd4, 32'd5);
    ticks = 0; got = 0;
    for (int i = 0; i < 4 * DIV && !got; i++) begin
      if (TICK) ticks++;
      step();
      n_vec++;
      if (IRQ !== m_irq()) begin n_err++; $display("FAIL oneshot_irq_track: got %b want %b", IRQ, m_irq()); end
      got = IRQ[1];
    end
    n_vec++;
    if (!got || ticks != 2) begin n_err++; $display("FAIL oneshot_ticks: got irq=%b ticks=%0d want 1/2", got, ticks); end
    ADDR = 6'd6; #1;
    n_vec++;
    if (RD !== 32'd2) begin n_err++; $display("FAIL oneshot_cnt: got %0d want 2", RD); end
    ADDR = 6'd4; #1;
    n_vec++;
    if (RD !== 32'h4) begin n_err++; $display("FAIL oneshot_ctrl: got %0h want 4", RD); end
    ADDR = 6'd7; #1;
    n_vec++;
    if (RD !== 32'd1) begin n_err++; $display("FAIL oneshot_flag: got %0d want 1", RD); end
    repeat (10 * DIV) step();
    ADDR = 6'd6; #1;
    n_vec++;
    if (RD !== 32'd2 || RD !== m_cnt[1]) begin n_err++; $display("FAIL oneshot_hold: got %0d want 2", RD); end
  endtask

  task automatic test_collision();
    logic found;
    wr(6'd3, 32'd1);
    found = 0;
    for (int i = 0; i < 5 * DIV; i++) begin
      if (m_tick() && m_en[0] && (m_cnt[0] + 32'd1 == m_cmp[0])) begin found = 1; break; end
      step();
    end
    if (!found) begin n_vec++; n_err++; $display("FAIL coll_w1c_wait: got timeout want match edge"); end
    else begin
      wr(6'd3, 32'd1);
      ADDR = 6'd3; #1;
      n_vec++;
      if (RD !== 32'd1 || IRQ[0] !== 1'b1) begin n_err++; $display("FAIL coll_w1c: got flag=%0d irq0=%b want 1/1", RD, IRQ[0]); end
    end
    found = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (m_tick()) begin found = 1; break; end
      step();
    end
    if (!found) begin n_vec++; n_err++; $display("FAIL coll_cnt_wait: got timeout want tick"); end
    else begin
      wr(6'd2, 32'd7);
      ADDR = 6'd2; #1;
      n_vec++;
      if (RD !== 32'd7) begin n_err++; $display("FAIL coll_cnt: got %0d want 7", RD); end
    end
    wr(6'd7, 32'd1);
    wr(6'd6, 32'd0);
    wr(6'd4, 32'd5);
    found = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      if (m_tick() && m_en[1] && (m_cnt[1] + 32'd1 == m_cmp[1])) begin found = 1; break; end
      step();
    end
    if (!found) begin n_vec++; n_err++; $display("FAIL coll_ctrl_wait: got timeout want match edge"); end
    else begin
      wr(6'd4, 32'd5);
      ADDR = 6'd4; #1;
      n_vec++;
      if (RD !== 32'h5) begin n_err++; $display("FAIL coll_ctrl: got %0h want 5", RD); end
      ADDR = 6'd7; #1;
      n_vec++;
      if (RD !== 32'd1) begin n_err++; $display("FAIL coll_ctrl_flag: got %0d want 1", RD); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  a;
    logic [31:0] d;
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 2))
        0, 1: begin
          case ($urandom_range(0, 9))
            8:       a = 6'h20;
            9:       a = 6'd9;
            default: a = 6'($urandom_range(0, 7));
          endcase
          case (a[1:0])
            2'd1:    d = $urandom_range(0, 4);
            2'd2:    d = $urandom_range(0, 5);
            default: d = $urandom();
          endcase
          wr(a, d);
        end
        default: repeat ($urandom_range(1, 60)) step();
      endcase
      a = ($urandom_range(0, 8) == 8) ? 6'h20 : 6'($urandom_range(0, 7));
      ADDR = a; #1;
      n_vec++;
      if (RD !== m_read(a) || IRQ !== m_irq() || TICK !== m_tick()) begin
        n_err++;
        $display("FAIL random_%0d addr=%0h: got rd=%0h irq=%b tick=%b want rd=%0h irq=%b tick=%b",
                 it, a, RD, IRQ, TICK, m_read(a), m_irq(), m_tick());
      end
    end
  endtask

  task automatic test_wrap();
    int seen;
    wr_b(6'd2, 32'hFE);
    wr_b(6'd0, 32'h1);
    seen = 0;
    for (int i = 0; i < 3 * DIV && seen < 2; i++) begin
      if (b_tick) seen++;
      step();
      if (b_tick === 1'b0 && seen == 1 && i >= 0) begin
        b_addr = 6'd2; #1;
        if (b_rd !== 32'hFF) begin n_vec++; n_err++; $display("FAIL wrap_ff: got %0h want ff", b_rd); seen = 3; end
      end
    end
    n_vec++;
    if (seen != 2) begin n_err++; $display("FAIL wrap_ticks: got %0d want 2", seen); end
    b_addr = 6'd2; #1;
    n_vec++;
    if (b_rd !== 32'h0) begin n_err++; $display("FAIL wrap_cnt: got %0h want 0", b_rd); end
    b_addr = 6'd3; #1;
    n_vec++;
    if (b_rd !== 32'h0 || b_irq !== 1'b0) begin n_err++; $display("FAIL wrap_flag: got %0h want 0", b_rd); end
    b_addr = 6'h20; #1;
    n_vec++;
    if (b_rd !== m_up) begin n_err++; $display("FAIL wrap_uptime: got %0d want %0d", b_rd, m_up); end
    wr_b(6'd1, 32'h1234_5603);
    b_addr = 6'd1; #1;
    n_vec++;
    if (b_rd !== 32'h03) begin n_err++; $display("FAIL wrap_cmp_trunc: got %0h want 3", b_rd); end
  endtask

  task automatic test_async_reset();
    logic [5:0] a;
    wr(6'd2, 32'd0);
    wr(6'd6, 32'd0);
    wr(6'd5, 32'd4);
    wr(6'd4, 32'd7);
    repeat (2 * DIV) step();
    b_addr = 6'd2;
    #3 RESET_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = (i == 4) ? 6'h20 : ((i < 2) ? 6'(2 + i) : 6'(4 + i));
      ADDR = a; #1;
      n_vec++;
      if (RD !== 32'd0) begin n_err++; $display("FAIL async_rd addr=%0h: got %0h want 0", a, RD); end
    end
    n_vec++;
    if (IRQ !== 2'b00 || TICK !== 1'b0 || b_rd !== 32'd0)
      begin n_err++; $display("FAIL async_out: got irq=%b tick=%b brd=%0h want 00/0/0", IRQ, TICK, b_rd); end
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    ADDR = 6'h20;
    repeat (DIV) step();
    n_vec++;
    if (RD !== 32'd1) begin n_err++; $display("FAIL async_restart: got %0d want 1", RD); end
    ADDR = 6'd0; #1;
    n_vec++;
    if (RD !== 32'd0) begin n_err++; $display("FAIL async_ctrl: got %0h want 0", RD); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_collision();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
